// File: rtl/hex_word_input_pkg.sv
// Shared I/O controller constants: handshake FSM encodings and word geometry.
package hex_word_input_pkg;

    localparam int DIGIT_W = 4;
    localparam int WORD_W  = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } stateT;

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stability counter,
// and a one-cycle pulse when the accepted level goes from released to pressed.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic resetIn,
    input  logic rawKey,
    output logic pressPulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             syncMeta;
    logic             syncKey;
    logic             stableLevel;
    logic [CNT_W-1:0] stableCount;

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            syncMeta    <= 1'b1;
            syncKey     <= 1'b1;
            stableLevel <= 1'b1;
            stableCount <= '0;
            pressPulse  <= 1'b0;
        end else begin
            syncMeta   <= rawKey;
            syncKey    <= syncMeta;
            pressPulse <= 1'b0;
            if (syncKey == stableLevel) begin
                stableCount <= '0;
            end else if (stableCount == CNT_W'(DEBOUNCE_CYCLES)) begin
                // Accept the new level; only a release-to-press change is an event.
                stableLevel <= syncKey;
                stableCount <= '0;
                pressPulse  <= ~syncKey;
            end else begin
                stableCount <= stableCount + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_word_input.sv
// Collects a word as hex digits keyed in MSB-first, returned to the requester
// over a four-phase enable/acknowledge handshake.
module hex_word_input
    import hex_word_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_DIGITS      = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetIn,
    input  logic               enable,
    output logic               acknowledge,
    input  logic [DIGIT_W-1:0] hexIn,
    input  logic               keyEnter,
    input  logic               keyBack,
    output logic [WORD_W-1:0]  dataOut,
    output logic [3:0]         digitCount,
    output logic               busy
);

    logic enterPulse;
    logic backPulse;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) enterDebounce (
        .CLOCK_50  (CLOCK_50),
        .resetIn   (resetIn),
        .rawKey    (keyEnter),
        .pressPulse(enterPulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) backDebounce (
        .CLOCK_50  (CLOCK_50),
        .resetIn   (resetIn),
        .rawKey    (keyBack),
        .pressPulse(backPulse)
    );

    stateT             stateReg, stateNext;
    logic [WORD_W-1:0] dataReg, dataNext;
    logic [3:0]        countReg, countNext;
    logic              ackReg, busyReg;

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            stateReg <= ST_IDLE;
            dataReg  <= '0;
            countReg <= '0;
            ackReg   <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            dataReg  <= dataNext;
            countReg <= countNext;
            // Flags track the state flops exactly, with no path from enable to the pins.
            ackReg   <= (stateNext == ST_DONE);
            busyReg  <= (stateNext == ST_COLLECT);
        end
    end

    always_comb begin
        stateNext = stateReg;
        dataNext  = dataReg;
        countNext = countReg;
        case (stateReg)
            ST_IDLE: begin
                if (enable) begin
                    stateNext = ST_COLLECT;
                    dataNext  = '0;
                    countNext = '0;
                end
            end
            ST_COLLECT: begin
                if (!enable) begin
                    stateNext = ST_IDLE;
                    dataNext  = '0;
                    countNext = '0;
                end else if (enterPulse && !backPulse) begin
                    dataNext  = {dataReg[WORD_W-DIGIT_W-1:0], hexIn};
                    countNext = countReg + 4'd1;
                    if (countReg + 4'd1 == 4'(NUM_DIGITS)) begin
                        stateNext = ST_DONE;
                    end
                end else if (backPulse && !enterPulse && countReg != 4'd0) begin
                    dataNext  = {{DIGIT_W{1'b0}}, dataReg[WORD_W-1:DIGIT_W]};
                    countNext = countReg - 4'd1;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                dataNext  = '0;
                countNext = '0;
            end
        endcase
    end

    assign acknowledge = ackReg;
    assign busy        = busyReg;
    assign dataOut     = dataReg;
    assign digitCount  = countReg;

endmodule

// File: doc/hex_word_input.md
Name: hex_word_input

Overview:
- Input-side counterpart of the hex display path: collects a 32-bit word as 8 hex digits entered on switches, confirmed digit by digit with a pushbutton.
- Serves a requester (CPU I/O controller) over the same four-phase enable/acknowledge handshake used by the display and RAM-transfer blocks.
- Digits shift in MSB-first, mirroring how the display block shifts nibbles out.
- Includes per-key synchronisation and debouncing so raw board buttons connect directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required before a key level is accepted (10 ms at 50 MHz).
- NUM_DIGITS, 8, digits per word; legal range 1..8.

Ports:
- CLOCK_50  input  1  system clock; all state on rising edge.
- resetIn  input  1  asynchronous, active-low reset.
- enable  input  1  request from initiator; level, held until acknowledge seen.
- acknowledge  output  1  word complete; held until enable drops.
- hexIn  input  4  digit value from switches, sampled at a confirmed press.
- keyEnter  input  1  raw pushbutton, active-low, asynchronous to CLOCK_50.
- keyBack  input  1  raw pushbutton, active-low; deletes the last digit.
- dataOut  output  32  assembled word; right-justified, most recent digit in [3:0].
- digitCount  output  4  digits entered so far, 0..NUM_DIGITS.
- busy  output  1  high while in COLLECT.

Behaviour:
- Reset (resetIn=0, asynchronous):
  - state=IDLE; acknowledge=0, busy=0, dataOut=0, digitCount=0.
  - Debouncers' stable level=1 (released); their counters=0.
- Key path (identical for each key):
  - 2-flop synchroniser.
  - Counter clears whenever the synchronised level equals the stable level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level takes the synchronised value and the counter clears.
  - A press event is a one-cycle pulse on the stable 1->0 transition. Releases generate nothing.
  - Counter width: $clog2(DEBOUNCE_CYCLES+1).
- Latency: a press held continuously produces its event within 2+DEBOUNCE_CYCLES+1 cycles of the falling edge. The register update is visible on the edge after the event.
- States:
  - IDLE (0):
    - enable=1 -> COLLECT.
    - On that transition edge, dataOut<=0 and digitCount<=0.
    - Key events ignored; dataOut holds the last completed word.
  - COLLECT (1), busy=1:
    - Enter event only: dataOut<={dataOut[27:0],hexIn}, digitCount+1.
    - If the new count equals NUM_DIGITS -> DONE on the same edge.
    - Back event only, digitCount>0: dataOut<={4'h0,dataOut[31:4]}, digitCount-1.
    - Back event with digitCount=0: no change.
    - Enter and back events in the same cycle: both ignored, no change.
    - enable=0: abort -> IDLE; dataOut and digitCount cleared; acknowledge is never asserted.
  - DONE (2):
    - acknowledge=1; dataOut and digitCount frozen; key events ignored.
    - Stays in DONE while enable=1.
    - enable=0 -> IDLE; acknowledge falls on that edge, and dataOut is retained.
  - Illegal encoding (3) -> IDLE with outputs cleared.
- acknowledge and busy are registered, decoded from state flops; no combinational path from enable.
- Key level changes during reset are discarded.
- Reset asserted mid-word returns all outputs to their reset values immediately.

Decomposition:
- Shared package (I/O controller constants):
  - State encodings ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_DONE=2'd2.
  - DIGIT_W=4, WORD_W=32.
- Sub-module key_debounce, instantiated twice:
  - Parameter DEBOUNCE_CYCLES.
  - Ports CLOCK_50, resetIn, rawKey, pressPulse.
  - Contains the synchroniser, counter and stable-level flop.
- Top level holds the FSM, shift register and digit counter. Benches run with DEBOUNCE_CYCLES=4.

Test Plan:
- Reset then enable=1, press keyEnter with hexIn=1,2,...,8 in turn -> acknowledge=1 and dataOut=32'h12345678, digitCount=8; drop enable -> acknowledge=0 next edge, dataOut still 32'h12345678.
- In COLLECT, enter A,B,C, press keyBack, enter D -> dataOut=32'h00000ABD, digitCount=3; keyBack at digitCount=0 -> dataOut=0, digitCount=0.
- keyEnter bouncing (toggle every 2 cycles for 20 cycles, then held low) -> exactly one digit accepted; a pulse shorter than DEBOUNCE_CYCLES -> none accepted.
- keyEnter and keyBack pressed in the same cycle with equal timing, digitCount=2 -> dataOut and digitCount unchanged.
- enable dropped after 5 digits -> IDLE with dataOut=0, digitCount=0, and acknowledge never pulses; in IDLE or DONE, key presses leave dataOut unchanged.
- resetIn pulsed low mid-word (digitCount=4) between clock edges -> all outputs 0 before the next rising edge; a fresh enable then produces a clean 8-digit collection.
